pipe_gap_spawner: RTL and testbench



---
 rtl/pipe_gap_spawner.sv | 172 +++++++++++++++++
 tb/tb_pipe_gap_spawner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_gap_spawner.sv
// pipe_gap_spawner
//   Schedules pipe spawns for the scroller. It counts frame ticks and, once
//   the interval runs out, samples the RNG byte and reduces it into a gap
//   centre. The new gap is limited to MAX_STEP away from the previous one, so
//   the course stays flyable, and is then offered over a valid/ready handshake.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   tick         in   one-cycle frame strobe
//   game_run     in   game in play (level); low aborts back to IDLE
//   rand_in      in   [7:0] RNG byte, only looked at in SAMPLE
//   spawn_ready  in   scroller accepts the offered pipe
//   spawn_valid  out  pipe offer pending
//   gap_y        out  [Y_W-1:0] gap centre of the offered pipe
//   spawn_count  out  [15:0] accepted spawns since reset, wraps to 0
//   busy         out  state machine is not IDLE
module pipe_gap_spawner #(
    parameter int Y_W         = 10,
    parameter int SPAWN_TICKS = 90,
    parameter int GAP_MIN     = 60,
    parameter int GAP_MAX     = 300,
    parameter int MAX_STEP    = 80
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    input  logic           game_run,
    input  logic [7:0]     rand_in,
    input  logic           spawn_ready,
    output logic           spawn_valid,
    output logic [Y_W-1:0] gap_y,
    output logic [15:0]    spawn_count,
    output logic           busy
);

    localparam int RANGE = GAP_MAX - GAP_MIN + 1;
    localparam int EXT_W = Y_W + 1;
    localparam int CNT_W = (SPAWN_TICKS > 1) ? $clog2(SPAWN_TICKS) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SPAWN_TICKS - 1);
    localparam logic [8:0]       RANGE_R   = 9'(RANGE);
    localparam logic [Y_W-1:0]   GAP_MID_Y = Y_W'((GAP_MIN + GAP_MAX) / 2);
    localparam logic [EXT_W-1:0] MIN_X     = EXT_W'(GAP_MIN);
    localparam logic [EXT_W-1:0] MAX_X     = EXT_W'(GAP_MAX);
    localparam logic [EXT_W-1:0] STEP_X    = EXT_W'(MAX_STEP);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        SAMPLE = 3'd2,
        MOD    = 3'd3,
        CLAMP  = 3'd4,
        OFFER  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       r;
    logic [Y_W-1:0]   last;

    // Step limit around the previous gap, then the legal screen band. All
    // arithmetic is one bit wider than gap_y so last+MAX_STEP cannot wrap,
    // and the lower limit is only applied when last-MAX_STEP is non-negative.
    function automatic logic [Y_W-1:0] clamp_gap(input logic [8:0]     rr,
                                                 input logic [Y_W-1:0] prev);
        logic [EXT_W-1:0] cand;
        logic [EXT_W-1:0] prev_x;
        logic [EXT_W-1:0] hi;
        logic [EXT_W-1:0] lo;
        prev_x = EXT_W'(prev);
        cand   = MIN_X + EXT_W'(rr);
        hi     = prev_x + STEP_X;
        lo     = '0;
        if (cand > hi) begin
            cand = hi;
        end
        if (prev_x >= STEP_X) begin
            lo = prev_x - STEP_X;
            if (cand < lo) begin
                cand = lo;
            end
        end
        if (cand < MIN_X) begin
            cand = MIN_X;
        end
        if (cand > MAX_X) begin
            cand = MAX_X;
        end
        return cand[Y_W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping game_run overrides everything, including a
    // handshake that would otherwise complete in OFFER.
    always_comb begin
        state_nxt = state;
        if (!game_run) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = WAIT;
                WAIT:    if (tick && (cnt == '0)) state_nxt = SAMPLE;
                SAMPLE:  state_nxt = MOD;
                MOD:     if (r < RANGE_R) state_nxt = CLAMP;
                CLAMP:   state_nxt = OFFER;
                OFFER:   if (spawn_ready) state_nxt = WAIT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        spawn_valid = (state == OFFER);
        busy        = (state != IDLE);
    end

    // Interval counter, range reduction and gap bookkeeping. The modulo is a
    // repeated subtraction: a byte needs at most 255/RANGE subtractions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= CNT_LOAD;
            r           <= '0;
            gap_y       <= GAP_MID_Y;
            last        <= GAP_MID_Y;
            spawn_count <= '0;
        end else if (game_run) begin
            case (state)
                IDLE: begin
                    cnt <= CNT_LOAD;
                end
                WAIT: begin
                    if (tick && (cnt != '0)) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    r <= {1'b0, rand_in};
                end
                MOD: begin
                    if (r >= RANGE_R) begin
                        r <= r - RANGE_R;
                    end
                end
                CLAMP: begin
                    gap_y <= clamp_gap(r, last);
                end
                OFFER: begin
                    if (spawn_ready) begin
                        last        <= gap_y;
                        spawn_count <= spawn_count + 16'd1;
                        cnt         <= CNT_LOAD;
                    end
                end
                default: begin
                    cnt <= CNT_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_gap_spawner.sv
module tb_pipe_gap_spawner;

    localparam int Y_W         = 10;
    localparam int SPAWN_TICKS = 4;
    localparam int GAP_MIN     = 60;
    localparam int GAP_MAX     = 300;
    localparam int MAX_STEP    = 80;
    localparam int RANGE       = GAP_MAX - GAP_MIN + 1;
    localparam int GAP_MID     = (GAP_MIN + GAP_MAX) / 2;

    logic           clk;
    logic           rst;
    logic           tick;
    logic           game_run;
    logic [7:0]     rand_in;
    logic           spawn_ready;
    logic           spawn_valid;
    logic [Y_W-1:0] gap_y;
    logic [15:0]    spawn_count;
    logic           busy;

    pipe_gap_spawner #(
        .Y_W(Y_W), .SPAWN_TICKS(SPAWN_TICKS), .GAP_MIN(GAP_MIN),
        .GAP_MAX(GAP_MAX), .MAX_STEP(MAX_STEP)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .game_run(game_run),
        .rand_in(rand_in), .spawn_ready(spawn_ready), .spawn_valid(spawn_valid),
        .gap_y(gap_y), .spawn_count(spawn_count), .busy(busy)
    );

    typedef struct {
        int gap;
        int exp_edge;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_m   = GAP_MID;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modulo, then limit to last +/- MAX_STEP, then the band.
    function automatic int model_gap(input int rv, input int prev);
        int c;
        c = GAP_MIN + (rv % RANGE);
        if (c > prev + MAX_STEP) c = prev + MAX_STEP;
        if (prev >= MAX_STEP && c < prev - MAX_STEP) c = prev - MAX_STEP;
        if (c < GAP_MIN) c = GAP_MIN;
        if (c > GAP_MAX) c = GAP_MAX;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue SPAWN_TICKS ticks; returns the cycle index of the terminal edge.
    task automatic run_interval(output int e0);
        e0 = 0;
        for (int i = 0; i < SPAWN_TICKS; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i == SPAWN_TICKS - 1) begin
                e0 = cyc;
            end else begin
                repeat ($urandom_range(0, 2)) step();
            end
        end
    endtask

    task automatic do_spawn(input int rv, input int ready_delay, input bit do_hs);
        int   e0;
        exp_t e;
        rand_in = rv[7:0];
        run_interval(e0);
        e.gap      = model_gap(rv, last_m);
        e.exp_edge = e0 + 3 + rv / RANGE;
        q.push_back(e);
        for (int k = 0; k < 20 && !spawn_valid; k++) begin
            tick = 1'($urandom_range(0, 1));
            step();
        end
        check("valid_seen", int'(spawn_valid), 1);
        if (!spawn_valid) begin
            tick = 1'b0;
            return;
        end
        if (!do_hs) begin
            tick = 1'b0;
            return;
        end
        for (int k = 0; k < ready_delay; k++) begin
            tick = 1'($urandom_range(0, 1));
            step();
        end
        tick        = 1'b0;
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        last_m      = e.gap;
    endtask

    // Monitor: pops the scoreboard on every new offer and tracks the count.
    int   exp_count  = 0;
    bit   prev_valid = 0;
    bit   hs_prev    = 0;
    int   held_gap   = 0;
    exp_t got;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_count  = 0;
            prev_valid = 0;
            hs_prev    = 0;
        end else begin
            check("spawn_count", int'(spawn_count), exp_count);
            if (hs_prev) check("valid_after_hs", int'(spawn_valid), 0);
            if (spawn_valid && !prev_valid) begin
                check("valid_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    got = q.pop_front();
                    check("gap_y", int'(gap_y), got.gap);
                    check("latency_edge", cyc, got.exp_edge);
                    held_gap = int'(gap_y);
                end
            end else if (spawn_valid && prev_valid) begin
                check("gap_y_stable", int'(gap_y), held_gap);
            end
            hs_prev = spawn_valid && spawn_ready && game_run;
            if (hs_prev) exp_count = (exp_count + 1) & 16'hFFFF;
            prev_valid = spawn_valid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e0;
        rst         = 1'b1;
        game_run    = 1'b0;
        tick        = 1'b0;
        spawn_ready = 1'b0;
        rand_in     = 8'd0;
        repeat (3) step();
        check("rst_valid", int'(spawn_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_gap_y", int'(gap_y), GAP_MID);
        check("rst_count", int'(spawn_count), 0);
        rst = 1'b0;
        step();
        check("idle_busy", int'(busy), 0);
        game_run = 1'b1;
        step();
        check("wait_busy", int'(busy), 1);

        // r=120, no subtraction: gap stays 180, valid 3 edges after terminal tick
        do_spawn(120, 2, 1);
        // r=250 -> 9, candidate 69 limited to 100; ready held off 10 cycles
        do_spawn(250, 10, 1);

        // Abort while in MOD: back to IDLE, no offer, count unchanged
        rand_in = 8'd250;
        run_interval(e0);
        step();
        game_run = 1'b0;
        step();
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(spawn_valid), 0);
        check("abort_gap_y", int'(gap_y), last_m);
        repeat (6) step();
        check("abort_idle_valid", int'(spawn_valid), 0);
        game_run = 1'b1;
        step();

        for (int n = 0; n < 30; n++) begin
            do_spawn(int'($urandom_range(0, 255)), int'($urandom_range(0, 4)), 1);
        end

        // Reset between clock edges while an offer is pending
        do_spawn(int'($urandom_range(0, 255)), 0, 0);
        check("pre_rst_valid", int'(spawn_valid), 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(spawn_valid), 0);
        check("async_rst_gap_y", int'(gap_y), GAP_MID);
        check("async_rst_count", int'(spawn_count), 0);
        check("async_rst_busy", int'(busy), 0);
        step();
        rst    = 1'b0;
        last_m = GAP_MID;
        step();
        // r=200 from last=180: candidate 260 is exactly last+MAX_STEP
        do_spawn(200, 1, 1);
        do_spawn(0, 0, 1);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
